// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program-memory arbiter.
// Holds the default widths, the default starvation limit and the encoding
// used to remember which requester owns the read that is in flight.
package prog_mem_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_ADDR_WIDTH   = 16;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

endpackage

// File: rtl/prog_mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the
// program memory.
//   f_*   : instruction-fetch read port (req/addr in, gnt/rvalid/rdata out)
//   d_*   : data port for Forth @ / ! (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   mem_* : program memory controls; mem_q is registered read data
// Modports:
//   slave  - arbiter view
//   master - requesters and memory view
interface prog_mem_arbiter_if
    import prog_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  f_req;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [DATA_WIDTH-1:0] f_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_read_addr, mem_write_addr, mem_data, mem_we
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_read_addr, mem_write_addr, mem_data, mem_we
    );

endinterface

// File: rtl/prog_mem_arbiter.sv
// Single-port program memory arbiter between instruction fetch and the
// Forth data port. Data wins by default; fetch is forced through after
// STARVE_LIMIT consecutive lost cycles. One access per cycle, reads return
// one cycle after grant on the rvalid of the requester that owned them.
// Ports:
//   clock   - single clock (also clocks the external memory)
//   reset_n - synchronous active-low reset
//   bus     - prog_mem_arbiter_if.slave (fetch, data and memory signals)
//
// owner state | meaning
// OWN_NONE    | no read issued last cycle, no rvalid this cycle
// OWN_FETCH   | fetch read issued last cycle, f_rvalid this cycle
// OWN_DATA    | data read issued last cycle, d_rvalid this cycle
module prog_mem_arbiter
    import prog_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input logic               clock,
    input logic               reset_n,
    prog_mem_arbiter_if.slave bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;
    owner_e        owner_q, owner_d;
    logic          override;
    logic          f_gnt, d_gnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            starve_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    always_comb begin
        override = bus.f_req && (starve_q == LIMIT);
        f_gnt    = reset_n && bus.f_req && (!bus.d_req || override);
        d_gnt    = reset_n && bus.d_req && !override;

        bus.f_gnt          = f_gnt;
        bus.d_gnt          = d_gnt;
        bus.mem_read_addr  = '0;
        bus.mem_write_addr = '0;
        bus.mem_data       = '0;
        bus.mem_we         = 1'b0;
        owner_d            = OWN_NONE;

        if (f_gnt) begin
            bus.mem_read_addr = bus.f_addr;
            owner_d           = OWN_FETCH;
        end else if (d_gnt && bus.d_we) begin
            bus.mem_write_addr = bus.d_addr;
            bus.mem_data       = bus.d_wdata;
            bus.mem_we         = 1'b1;
        end else if (d_gnt) begin
            bus.mem_read_addr = bus.d_addr;
            owner_d           = OWN_DATA;
        end

        if (bus.f_req && !f_gnt) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CW'(1);
        end else begin
            starve_d = '0;
        end

        // Gating with reset_n drops a read granted just before reset asserts.
        bus.f_rvalid = reset_n && (owner_q == OWN_FETCH);
        bus.d_rvalid = reset_n && (owner_q == OWN_DATA);
        bus.f_rdata  = bus.f_rvalid ? bus.mem_q : '0;
        bus.d_rdata  = bus.d_rvalid ? bus.mem_q : '0;
    end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
module tb_prog_mem_arbiter;
    import prog_mem_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int AW = DEF_ADDR_WIDTH;
    localparam int SL = DEF_STARVE_LIMIT;
    localparam int MEM_WORDS = 1 << AW;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    prog_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    prog_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Program memory: registered read, write at the edge.
    logic [DW-1:0] mem [0:MEM_WORDS-1];
    always @(posedge clock) begin
        if (bus.mem_we) mem[bus.mem_write_addr] <= bus.mem_data;
        bus.mem_q <= mem[bus.mem_read_addr];
    end

    // Reference model state
    logic [DW-1:0] shadow [0:MEM_WORDS-1];
    typedef struct {
        bit            is_fetch;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];
    int   starve = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Drive one cycle, check grants/memory controls against the arbitration
    // rules, and queue the read data the memory should return next cycle.
    task automatic step(input bit rst_n, input bit fr, input logic [AW-1:0] fa,
                        input bit dr, input bit dwe, input logic [AW-1:0] da,
                        input logic [DW-1:0] dwd, output bit fg, output bit dg);
        bit ov, eg_f, eg_d, exp_we;
        logic [AW-1:0] exp_ra, exp_wa;
        logic [DW-1:0] exp_wd;
        @(posedge clock);
        #1;
        reset_n       = rst_n;
        bus.f_req     = fr;
        bus.f_addr    = fa;
        bus.d_req     = dr;
        bus.d_we      = dwe;
        bus.d_addr    = da;
        bus.d_wdata   = dwd;
        #1;
        ov     = fr && (starve == SL);
        eg_f   = rst_n && fr && (!dr || ov);
        eg_d   = rst_n && dr && !ov;
        exp_we = eg_d && dwe;
        exp_ra = eg_f ? fa : ((eg_d && !dwe) ? da : '0);
        exp_wa = exp_we ? da : '0;
        exp_wd = exp_we ? dwd : '0;
        chk("f_gnt", 32'(bus.f_gnt), 32'(eg_f));
        chk("d_gnt", 32'(bus.d_gnt), 32'(eg_d));
        chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
        chk("mem_read_addr", 32'(bus.mem_read_addr), 32'(exp_ra));
        chk("mem_write_addr", 32'(bus.mem_write_addr), 32'(exp_wa));
        chk("mem_data", 32'(bus.mem_data), 32'(exp_wd));
        if (!rst_n) begin
            sb.delete();
            starve = 0;
            chk("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
            chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        end else begin
            if (eg_f) sb.push_back('{1'b1, shadow[fa], cyc + 1});
            else if (eg_d && !dwe) sb.push_back('{1'b0, shadow[da], cyc + 1});
            if (exp_we) shadow[da] = dwd;
            starve = (fr && !eg_f) ? ((starve < SL) ? starve + 1 : SL) : 0;
        end
        fg = eg_f;
        dg = eg_d;
    endtask

    // Monitor: every cycle out of reset, the read queued for this cycle (if
    // any) must appear on exactly the right rvalid with the right data.
    exp_t       mon_e;
    logic [1:0] mon_own;
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                mon_own = {bus.d_rvalid, bus.f_rvalid};
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    mon_e = sb.pop_front();
                    chk("rvalid_owner", 32'(mon_own), mon_e.is_fetch ? 32'd1 : 32'd2);
                    chk("rdata", mon_e.is_fetch ? 32'(bus.f_rdata) : 32'(bus.d_rdata), 32'(mon_e.data));
                end else begin
                    chk("rvalid_idle", 32'(mon_own), 32'd0);
                end
                if (!bus.f_rvalid) chk("f_rdata_zero", 32'(bus.f_rdata), 32'd0);
                if (!bus.d_rvalid) chk("d_rdata_zero", 32'(bus.d_rdata), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    bit fg, dg;
    bit fp, dp, dp_we;
    logic [AW-1:0] fp_addr, dp_addr;
    logic [DW-1:0] dp_wdata;

    initial begin
        bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]    = (i < 64) ? DW'($urandom) : '0;
            shadow[i] = mem[i];
        end
        mem[16'h0010] = 16'hBEEF;
        shadow[16'h0010] = 16'hBEEF;

        // Reset with both requesters active: no grants, no mem_we
        step(0, 1, 16'h0001, 1, 1, 16'h0002, 16'h5555, fg, dg);
        step(0, 1, 16'h0001, 1, 0, 16'h0002, 16'h0000, fg, dg);
        step(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, fg, dg);

        // Lone fetch of 0x0010 -> 0xBEEF
        step(1, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, fg, dg);
        step(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, fg, dg);

        // Collision: data read of 0x0020 wins, fetch then follows
        step(1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, fg, dg);
        step(1, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, fg, dg);
        step(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, fg, dg);

        // Starvation: data held 6 cycles, fetch forced through in cycle 4
        for (int i = 0; i < 6; i++)
            step(1, 1, 16'h0030, 1, 0, AW'(40 + i), 16'h0000, fg, dg);
        step(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, fg, dg);

        // Write 0x1234 to 0x0005, fetch 0x0005 next cycle
        step(1, 0, 16'h0000, 1, 1, 16'h0005, 16'h1234, fg, dg);
        step(1, 1, 16'h0005, 0, 0, 16'h0000, 16'h0000, fg, dg);
        step(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, fg, dg);

        // Reset right after a granted fetch: its rvalid must never show
        step(1, 1, 16'h0011, 0, 0, 16'h0000, 16'h0000, fg, dg);
        step(0, 1, 16'h0011, 1, 1, 16'h0003, 16'hAAAA, fg, dg);
        step(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, fg, dg);
        step(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, fg, dg);

        // Alternating fetch/data reads, back-to-back
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1, 1, AW'(i), 0, 0, 16'h0000, 16'h0000, fg, dg);
            else            step(1, 0, 16'h0000, 1, 0, AW'(32 + i), 16'h0000, fg, dg);
        end

        // Randomized traffic: requesters hold until granted, sometimes drop
        fp = 0; dp = 0; dp_we = 0; fp_addr = '0; dp_addr = '0; dp_wdata = '0;
        for (int n = 0; n < 500; n++) begin
            if (!fp && ($urandom_range(0, 2) != 0)) begin
                fp = 1; fp_addr = AW'($urandom_range(0, 63));
            end else if (fp && ($urandom_range(0, 15) == 0)) begin
                fp = 0;
            end
            if (!dp && ($urandom_range(0, 2) != 0)) begin
                dp = 1; dp_we = 1'($urandom_range(0, 1));
                dp_addr = AW'($urandom_range(0, 63)); dp_wdata = DW'($urandom);
            end else if (dp && ($urandom_range(0, 15) == 0)) begin
                dp = 0;
            end
            if ($urandom_range(0, 99) == 0) begin
                step(0, fp, fp_addr, dp, dp_we, dp_addr, dp_wdata, fg, dg);
                fp = 0; dp = 0;
            end else begin
                step(1, fp, fp_addr, dp, dp_we, dp_addr, dp_wdata, fg, dg);
                if (fg) fp = 0;
                if (dg) dp = 0;
            end
        end

        for (int i = 0; i < 3; i++)
            step(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, fg, dg);
        @(posedge clock);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_mem_arbiter.md
PROG_MEM_ARBITER -- requirements
Module: prog_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning program word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning program address width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive lost fetch cycles before fetch is forced to win.
REQ-004 SHALL have port clock, input, 1 bit: the single clock, which also drives the memory read_clock and write_clock.
REQ-005 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port f_req, input, 1 bit: instruction-fetch read request.
REQ-007 SHALL have port f_addr, input, ADDR_WIDTH bits: fetch address.
REQ-008 SHALL have ports f_gnt (output, 1), f_rvalid (output, 1) and f_rdata (output, DATA_WIDTH): fetch grant, fetch read-data valid, and fetch read data.
REQ-009 SHALL have ports d_req (input, 1), d_we (input, 1), d_addr (input, ADDR_WIDTH) and d_wdata (input, DATA_WIDTH): data-port (Forth @ / !) request, write enable, address, and write data.
REQ-010 SHALL have ports d_gnt (output, 1), d_rvalid (output, 1) and d_rdata (output, DATA_WIDTH): data grant, data read valid, and data read data.
REQ-011 SHALL have ports mem_read_addr (output, ADDR_WIDTH), mem_write_addr (output, ADDR_WIDTH), mem_data (output, DATA_WIDTH) and mem_we (output, 1): the program memory write/read controls.
REQ-012 SHALL have port mem_q, input, DATA_WIDTH bits: the registered memory read data, valid one clock after its address is presented.

Function
REQ-013 SHALL grant at most one requester per cycle; f_gnt and d_gnt are combinational from the requests and internal state, in the same cycle as the request.
REQ-014 SHALL give the data port priority by default: if d_req=1, then d_gnt=1, unless the starvation override applies.
REQ-015 SHALL keep a saturating starve counter (0..STARVE_LIMIT): it increments on each cycle with f_req=1 and f_gnt=0, and clears on any cycle with f_gnt=1 or f_req=0.
REQ-016 SHALL, when the starve counter equals STARVE_LIMIT and f_req=1, grant fetch and deny data that cycle (override).
REQ-017 SHALL, on a fetch grant, drive mem_read_addr=f_addr and mem_we=0.
REQ-018 SHALL, on a data read grant (d_we=0), drive mem_read_addr=d_addr and mem_we=0.
REQ-019 SHALL, on a data write grant, drive mem_write_addr=d_addr, mem_data=d_wdata and mem_we=1; the write completes at the grant edge and produces no rvalid.
REQ-020 SHALL, when nothing is granted, drive mem_we=0 and all mem address/data outputs to 0.
REQ-021 SHALL register the owner of each granted read; in the next cycle it asserts exactly one of f_rvalid or d_rvalid for one cycle, with the matching rdata equal to mem_q.
REQ-022 SHALL hold f_rdata and d_rdata at 0 whenever their rvalid is 0.
REQ-023 SHALL sustain back-to-back grants at one access per cycle; a grant is not blocked by an rvalid pending from the prior cycle.
REQ-024 SHALL, for a data write to address A in cycle N and a fetch of A in cycle N+1, return the new data at N+2 (the memory writes before it reads).
REQ-025 SHALL, when a requester deasserts req without a grant, drop the request with no side effect; requesters hold req/addr/wdata stable until granted.

Reset
REQ-026 SHALL, while reset_n=0 at a clock edge, clear the starve counter, the read-owner register, f_rvalid and d_rvalid.
REQ-027 SHALL force f_gnt, d_gnt and mem_we to 0 while reset_n=0.
REQ-028 SHALL suppress a read granted in the cycle before reset asserts: no rvalid is produced after reset.

Structure
REQ-029 SHALL place the default widths, STARVE_LIMIT default and the read-owner encoding (NONE, FETCH, DATA) in the shared package prog_mem_pkg.
REQ-030 SHALL be flat with no sub-module; the memory instance sits outside, at the parent level.

Verification
REQ-031 SHALL verify a lone fetch: f_req=1, f_addr=0x0010, memory[0x0010]=0xBEEF -> f_gnt same cycle, then f_rvalid=1 with f_rdata=0xBEEF the next cycle.
REQ-032 SHALL verify a collision: f_req=d_req=1, d_we=0, d_addr=0x0020 -> d_gnt=1, f_gnt=0, then d_rvalid next cycle with f_rvalid=0.
REQ-033 SHALL verify starvation: d_req held high for 6 cycles with f_req high -> data wins cycles 0-3, fetch is granted in cycle 4, and the counter clears.
REQ-034 SHALL verify write-then-fetch: a data write of 0x1234 to 0x0005, then a fetch of 0x0005 next cycle -> f_rdata=0x1234 with no rvalid for the write.
REQ-035 SHALL verify reset mid-read: a fetch granted, then reset_n=0 the next edge -> f_rvalid stays 0, and grants and mem_we are 0 during reset.
REQ-036 SHALL verify alternating fetch/data reads for 8 cycles -> one rvalid per cycle with the correct owner and data, and no gaps.
